// File: rtl/riscv_mem_pkg.sv
// riscv_mem_pkg
// Shared definitions for the data-memory controller:
//   - RV32I funct3 access-size codes (MEM_B, MEM_H, MEM_W, MEM_BU, MEM_HU)
//   - controller state encoding
//   - size_mask(): byte-lane mask of an access before it is shifted by the
//     byte offset
package riscv_mem_pkg;

    localparam logic [2:0] MEM_B  = 3'b000;
    localparam logic [2:0] MEM_H  = 3'b001;
    localparam logic [2:0] MEM_W  = 3'b010;
    localparam logic [2:0] MEM_BU = 3'b100;
    localparam logic [2:0] MEM_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LD1  = 2'd1,
        LD2  = 2'd2,
        ST2  = 2'd3
    } mem_state_e;

    // Lanes touched by an access of this size at offset 0. Unknown codes
    // behave as full-word accesses.
    function automatic logic [3:0] size_mask(input logic [2:0] unit_size);
        logic [3:0] mask;
        case (unit_size)
            MEM_B, MEM_BU: mask = 4'b0001;
            MEM_H, MEM_HU: mask = 4'b0011;
            default:       mask = 4'b1111;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/dmem_ctrl_load_formatter.sv
// load_formatter
// Purely combinational load alignment and extension.
// Ports:
//   window   in  64  {hi, lo} pair of SRAM words (hi is zero for aligned loads)
//   off      in  2   byte offset of the access within lo
//   unitSize in  3   funct3 size/sign code
//   result   out 32  load value shifted down to bit 0 and extended
module load_formatter
    import riscv_mem_pkg::*;
(
    input  logic [63:0] window,
    input  logic [1:0]  off,
    input  logic [2:0]  unitSize,
    output logic [31:0] result
);

    logic [31:0] aligned;
    // An access never extends past byte 6 of the window, so the top byte
    // is never selected.
    logic        unused_window_top;

    assign unused_window_top = ^window[63:56];

    always_comb begin
        aligned = window[31:0];
        case (off)
            2'd0:    aligned = window[31:0];
            2'd1:    aligned = window[39:8];
            2'd2:    aligned = window[47:16];
            default: aligned = window[55:24];
        endcase
    end

    always_comb begin
        result = aligned;
        case (unitSize)
            MEM_B:   result = {{24{aligned[7]}}, aligned[7:0]};
            MEM_BU:  result = {24'h0, aligned[7:0]};
            MEM_H:   result = {{16{aligned[15]}}, aligned[15:0]};
            MEM_HU:  result = {16'h0, aligned[15:0]};
            default: result = aligned;
        endcase
    end

endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl
// Data-memory controller between the MEM stage and a word-wide synchronous
// single-port SRAM. Byte/halfword/word loads and stores; accesses that cross
// a word boundary are split into two SRAM accesses while the core is stalled.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   readEnable, writeEnable  load / store request (store wins if both set)
//   addr                     byte address
//   unitSize                 funct3 size code
//   writeData                store data, LSB-aligned
//   readData                 extended load result (held between loads)
//   busy                     combinational stall to the core
//   ramEn, ramWe, ramAddr,   SRAM access enable, per-lane write enables,
//   ramWData, ramRData       word address, write data, read data (1-cycle)
module dmem_ctrl
    import riscv_mem_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              readEnable,
    input  logic              writeEnable,
    input  logic [31:0]       addr,
    input  logic [2:0]        unitSize,
    input  logic [31:0]       writeData,
    output logic [31:0]       readData,
    output logic              busy,
    output logic              ramEn,
    output logic [3:0]        ramWe,
    output logic [ADDR_W-1:0] ramAddr,
    output logic [31:0]       ramWData,
    input  logic [31:0]       ramRData
);

    mem_state_e state_q, state_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] read_data_q, read_data_d;

    logic [ADDR_W-1:0] w0, w1;
    logic [1:0]        off;
    logic [7:0]        lane_wide;
    logic [63:0]       wdata_wide;
    logic              misaligned;
    logic              unused_addr_hi;

    logic              busy_c;
    logic              ram_en_c;
    logic [3:0]        ram_we_c;
    logic [ADDR_W-1:0] ram_addr_c;
    logic [31:0]       ram_wdata_c;
    logic              complete_c;

    logic [63:0]       window;
    logic [31:0]       fmt_result;

    assign w0             = addr[ADDR_W+1:2];
    assign w1             = w0 + {{(ADDR_W-1){1'b0}}, 1'b1};
    assign off            = addr[1:0];
    assign unused_addr_hi = ^addr[31:ADDR_W+2];

    // Lane mask and write data are built over two words: the low half goes
    // to w0, anything shifted past lane 3 belongs to w1. A non-empty high
    // half is exactly the misaligned case for both loads and stores.
    assign lane_wide  = {4'b0000, size_mask(unitSize)} << off;
    assign wdata_wide = {32'h0, writeData} << {off, 3'b000};
    assign misaligned = |lane_wide[7:4];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            lo_q        <= '0;
            read_data_q <= '0;
        end else begin
            state_q     <= state_d;
            lo_q        <= lo_d;
            read_data_q <= read_data_d;
        end
    end

    // Next state and SRAM drive. Request inputs are held stable by the core
    // while busy, so the second half of a split access re-derives its
    // address and lanes from addr rather than from saved copies.
    always_comb begin
        state_d     = state_q;
        lo_d        = lo_q;
        busy_c      = 1'b0;
        ram_en_c    = 1'b0;
        ram_we_c    = 4'b0000;
        ram_addr_c  = '0;
        ram_wdata_c = '0;
        complete_c  = 1'b0;
        case (state_q)
            IDLE: begin
                if (writeEnable) begin
                    ram_en_c    = 1'b1;
                    ram_we_c    = lane_wide[3:0];
                    ram_addr_c  = w0;
                    ram_wdata_c = wdata_wide[31:0];
                    if (misaligned) begin
                        busy_c  = 1'b1;
                        state_d = ST2;
                    end
                end else if (readEnable) begin
                    ram_en_c   = 1'b1;
                    ram_addr_c = w0;
                    busy_c     = 1'b1;
                    state_d    = LD1;
                end
            end
            ST2: begin
                ram_en_c    = 1'b1;
                ram_we_c    = lane_wide[7:4];
                ram_addr_c  = w1;
                ram_wdata_c = wdata_wide[63:32];
                state_d     = IDLE;
            end
            LD1: begin
                if (misaligned) begin
                    lo_d       = ramRData;
                    ram_en_c   = 1'b1;
                    ram_addr_c = w1;
                    busy_c     = 1'b1;
                    state_d    = LD2;
                end else begin
                    complete_c = 1'b1;
                    state_d    = IDLE;
                end
            end
            LD2: begin
                complete_c = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Kept separate from the FSM block so the formatter path does not form
    // a false combinational loop through that block.
    always_comb begin
        window = {32'h0, ramRData};
        if (state_q == LD2) begin
            window = {ramRData, lo_q};
        end
    end

    load_formatter u_load_formatter (
        .window   (window),
        .off      (off),
        .unitSize (unitSize),
        .result   (fmt_result)
    );

    assign read_data_d = complete_c ? fmt_result : read_data_q;

    // While reset is asserted nothing reaches the SRAM or the core, so an
    // access aborted in ST2 never issues its second write.
    assign busy     = busy_c & ~rst;
    assign ramEn    = ram_en_c & ~rst;
    assign ramWe    = rst ? 4'b0000 : ram_we_c;
    assign ramAddr  = rst ? '0 : ram_addr_c;
    assign ramWData = rst ? 32'h0 : ram_wdata_c;
    assign readData = (complete_c & ~rst) ? fmt_result : read_data_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl
// Self-checking bench for dmem_ctrl with a 16-word behavioural SRAM.
// Expected load results are queued when a load is issued and popped when the
// controller signals completion; SRAM traffic is logged at every negedge.
module tb_dmem_ctrl;
    import riscv_mem_pkg::*;

    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          readEnable = 1'b0;
    logic          writeEnable = 1'b0;
    logic [31:0]   addr = 32'h0;
    logic [2:0]    unitSize = 3'b000;
    logic [31:0]   writeData = 32'h0;
    logic [31:0]   readData;
    logic          busy;
    logic          ramEn;
    logic [3:0]    ramWe;
    logic [AW-1:0] ramAddr;
    logic [31:0]   ramWData;
    logic [31:0]   ramRData = 32'h0;

    logic [31:0]   mem [16] = '{default: 32'h0};
    logic          pre_en = 1'b0;
    logic [AW-1:0] pre_addr = '0;
    logic [31:0]   pre_data = 32'h0;

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [3:0]    we;
        logic [31:0]   d;
    } acc_t;

    acc_t        acc_log[$];
    logic [31:0] exp_q[$];

    dmem_ctrl #(.ADDR_W(AW)) dut (
        .clk         (clk),
        .rst         (rst),
        .readEnable  (readEnable),
        .writeEnable (writeEnable),
        .addr        (addr),
        .unitSize    (unitSize),
        .writeData   (writeData),
        .readData    (readData),
        .busy        (busy),
        .ramEn       (ramEn),
        .ramWe       (ramWe),
        .ramAddr     (ramAddr),
        .ramWData    (ramWData),
        .ramRData    (ramRData)
    );

    always #5 clk = ~clk;

    // Synchronous SRAM: read data one cycle after a read, write-through on
    // writes so a stray read-completion after a store would be visible.
    always @(posedge clk) begin
        if (pre_en) begin
            mem[pre_addr] <= pre_data;
        end else if (ramEn) begin
            if (ramWe != 4'b0000) begin
                for (int i = 0; i < 4; i++) begin
                    if (ramWe[i]) mem[ramAddr][8*i +: 8] <= ramWData[8*i +: 8];
                end
                ramRData <= ramWData;
            end else begin
                ramRData <= mem[ramAddr];
            end
        end
    end

    // Log every SRAM access, sampled away from the active edge.
    always @(negedge clk) begin
        if (ramEn) acc_log.push_back({ramAddr, ramWe, ramWData});
    end

    task automatic preload(input int a, input logic [31:0] d);
        @(posedge clk); #1;
        pre_en = 1'b1; pre_addr = AW'(a); pre_data = d;
        @(posedge clk); #1;
        pre_en = 1'b0;
    endtask

    // Issue one load and wait for its completion cycle.
    task automatic apply_load(input logic [31:0] a, input logic [2:0] u,
                              output logic [31:0] data, output int stalls, output bit timeout);
        @(posedge clk); #1;
        readEnable = 1'b1; writeEnable = 1'b0; addr = a; unitSize = u;
        stalls = 0; timeout = 1'b1; data = 32'h0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (!busy) begin
                data = readData; timeout = 1'b0;
                break;
            end
            stalls++;
        end
        @(posedge clk); #1;
        readEnable = 1'b0;
    endtask

    // Issue one store and wait for its completion cycle.
    task automatic apply_store(input logic [31:0] a, input logic [2:0] u, input logic [31:0] d,
                               output int stalls, output bit timeout);
        @(posedge clk); #1;
        writeEnable = 1'b1; readEnable = 1'b0; addr = a; unitSize = u; writeData = d;
        stalls = 0; timeout = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (!busy) begin
                timeout = 1'b0;
                break;
            end
            stalls++;
        end
        @(posedge clk); #1;
        writeEnable = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        tests_run++;
        if ({busy, ramEn, ramWe, ramAddr, ramWData} !== '0) begin
            tests_failed++;
            $display("[TB] FAIL reset_outputs: got busy=%b en=%b we=%b addr=%h wdata=%h, expected all zero",
                     busy, ramEn, ramWe, ramAddr, ramWData);
        end
        tests_run++;
        if (readData !== 32'h0) begin
            tests_failed++;
            $display("[TB] FAIL reset_readData: got %h expected 00000000", readData);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        tests_run++;
        if ({busy, ramEn, readData} !== '0) begin
            tests_failed++;
            $display("[TB] FAIL idle_after_reset: got busy=%b en=%b rd=%h expected 0/0/0", busy, ramEn, readData);
        end
    endtask

    task automatic test_aligned_load();
        logic [31:0] got, want;
        int st;
        bit to;
        preload(5, 32'h11223344);
        acc_log.delete();
        exp_q.push_back(32'h11223344);
        apply_load(32'h14, MEM_W, got, st, to);
        want = exp_q.pop_front();
        tests_run++;
        if (to || st != 1) begin
            tests_failed++;
            $display("[TB] FAIL lw_stalls: got %0d (timeout=%0d) expected 1", st, to);
        end
        tests_run++;
        if (got !== want) begin
            tests_failed++;
            $display("[TB] FAIL lw_data: got %h expected %h", got, want);
        end
        tests_run++;
        if (acc_log.size() != 1 || acc_log[0] !== {4'd5, 4'b0000, 32'h0}) begin
            tests_failed++;
            $display("[TB] FAIL lw_access: got %0d accesses, expected one read of word 5", acc_log.size());
        end
    endtask

    task automatic test_subword_loads();
        logic [31:0] la [4] = '{32'h17, 32'h17, 32'h16, 32'h16};
        logic [2:0]  lu [4] = '{MEM_B, MEM_BU, MEM_H, MEM_HU};
        logic [31:0] lx [4] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h000080FF};
        logic [31:0] got, want;
        int st;
        bit to;
        preload(5, 32'h80FF0000);
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back(lx[k]);
            apply_load(la[k], lu[k], got, st, to);
            want = exp_q.pop_front();
            tests_run++;
            if (to || st != 1 || got !== want) begin
                tests_failed++;
                $display("[TB] FAIL subword_load_%0d: got %h stalls %0d expected %h stalls 1", k, got, st, want);
            end
        end
    endtask

    task automatic test_misaligned_load();
        logic [31:0] got, want;
        int st;
        bit to;
        preload(5, 32'hAABBCCDD);
        preload(6, 32'h11223344);
        acc_log.delete();
        exp_q.push_back(32'h3344AABB);
        apply_load(32'h16, MEM_W, got, st, to);
        want = exp_q.pop_front();
        tests_run++;
        if (to || st != 2) begin
            tests_failed++;
            $display("[TB] FAIL mis_lw_stalls: got %0d (timeout=%0d) expected 2", st, to);
        end
        tests_run++;
        if (got !== want) begin
            tests_failed++;
            $display("[TB] FAIL mis_lw_data: got %h expected %h", got, want);
        end
        tests_run++;
        if (acc_log.size() != 2 || acc_log[0].a !== 4'd5 || acc_log[1].a !== 4'd6
            || acc_log[0].we !== 4'b0000 || acc_log[1].we !== 4'b0000) begin
            tests_failed++;
            $display("[TB] FAIL mis_lw_access: got %0d accesses, expected reads of words 5 then 6", acc_log.size());
        end
        preload(5, 32'h80FF0000);
        preload(6, 32'h112233C4);
        exp_q.push_back(32'hFFFFC480);
        apply_load(32'h17, MEM_H, got, st, to);
        want = exp_q.pop_front();
        tests_run++;
        if (to || st != 2 || got !== want) begin
            tests_failed++;
            $display("[TB] FAIL mis_lh: got %h stalls %0d expected %h stalls 2", got, st, want);
        end
        exp_q.push_back(32'h0000C480);
        apply_load(32'h17, MEM_HU, got, st, to);
        want = exp_q.pop_front();
        tests_run++;
        if (to || st != 2 || got !== want) begin
            tests_failed++;
            $display("[TB] FAIL mis_lhu: got %h stalls %0d expected %h stalls 2", got, st, want);
        end
    endtask

    task automatic test_stores();
        logic [31:0] got, want;
        int st;
        bit to;
        preload(2, 32'h11111111);
        preload(3, 32'h22222222);
        acc_log.delete();
        apply_store(32'h0B, MEM_H, 32'h0000BEEF, st, to);
        tests_run++;
        if (to || st != 1) begin
            tests_failed++;
            $display("[TB] FAIL mis_sh_stalls: got %0d (timeout=%0d) expected 1", st, to);
        end
        tests_run++;
        if (acc_log.size() != 2 || acc_log[0] !== {4'd2, 4'b1000, 32'hEF000000}
            || acc_log[1] !== {4'd3, 4'b0001, 32'h000000BE}) begin
            tests_failed++;
            $display("[TB] FAIL mis_sh_access: got %0d accesses, first %h, expected 2:EF000000/8 then 3:000000BE/1",
                     acc_log.size(), acc_log.size() > 0 ? acc_log[0] : '0);
        end
        tests_run++;
        if (mem[2] !== 32'hEF111111 || mem[3] !== 32'h222222BE) begin
            tests_failed++;
            $display("[TB] FAIL mis_sh_mem: got %h %h expected EF111111 222222BE", mem[2], mem[3]);
        end
        exp_q.push_back(32'h0000BEEF);
        apply_load(32'h0B, MEM_HU, got, st, to);
        want = exp_q.pop_front();
        tests_run++;
        if (to || got !== want) begin
            tests_failed++;
            $display("[TB] FAIL mis_sh_readback: got %h expected %h", got, want);
        end
        acc_log.delete();
        apply_store(32'h0D, MEM_W, 32'h01020304, st, to);
        tests_run++;
        if (to || st != 1 || acc_log.size() != 2 || acc_log[0] !== {4'd3, 4'b1110, 32'h02030400}
            || acc_log[1] !== {4'd4, 4'b0001, 32'h00000001}) begin
            tests_failed++;
            $display("[TB] FAIL mis_sw_access: got %0d accesses stalls %0d, expected 3:02030400/E then 4:00000001/1",
                     acc_log.size(), st);
        end
        exp_q.push_back(32'h01020304);
        apply_load(32'h0D, MEM_W, got, st, to);
        want = exp_q.pop_front();
        tests_run++;
        if (to || got !== want) begin
            tests_failed++;
            $display("[TB] FAIL mis_sw_readback: got %h expected %h", got, want);
        end
        preload(1, 32'h0);
        acc_log.delete();
        apply_store(32'h05, MEM_B, 32'hFFFFFFA5, st, to);
        apply_store(32'h06, MEM_H, 32'h00001234, st, to);
        tests_run++;
        if (to || st != 0 || acc_log.size() != 2 || acc_log[0] !== {4'd1, 4'b0010, 32'hFFFFA500}
            || acc_log[1] !== {4'd1, 4'b1100, 32'h12340000}) begin
            tests_failed++;
            $display("[TB] FAIL aligned_store_access: got %0d accesses stalls %0d, expected 1/0010 then 1/1100",
                     acc_log.size(), st);
        end
        exp_q.push_back(32'h1234A500);
        apply_load(32'h04, MEM_W, got, st, to);
        want = exp_q.pop_front();
        tests_run++;
        if (to || got !== want) begin
            tests_failed++;
            $display("[TB] FAIL aligned_store_readback: got %h expected %h", got, want);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] got, want;
        int st;
        bit to;
        preload(15, 32'h55667788);
        preload(0, 32'h9900AABB);
        acc_log.delete();
        exp_q.push_back(32'hAABB5566);
        apply_load(32'h3E, MEM_W, got, st, to);
        want = exp_q.pop_front();
        tests_run++;
        if (acc_log.size() != 2 || acc_log[0].a !== 4'd15 || acc_log[1].a !== 4'd0) begin
            tests_failed++;
            $display("[TB] FAIL wrap_access: got %0d accesses, expected reads of word 15 then 0", acc_log.size());
        end
        tests_run++;
        if (to || st != 2 || got !== want) begin
            tests_failed++;
            $display("[TB] FAIL wrap_data: got %h stalls %0d expected %h stalls 2", got, st, want);
        end
    endtask

    task automatic test_priority();
        logic [31:0] prev;
        prev = readData;
        acc_log.delete();
        @(posedge clk); #1;
        readEnable = 1'b1; writeEnable = 1'b1; addr = 32'h0; unitSize = MEM_W; writeData = 32'h12345678;
        @(negedge clk);
        tests_run++;
        if (busy !== 1'b0 || ramEn !== 1'b1 || ramWe !== 4'b1111) begin
            tests_failed++;
            $display("[TB] FAIL priority_write: got busy=%b en=%b we=%b expected 0/1/1111", busy, ramEn, ramWe);
        end
        @(posedge clk); #1;
        readEnable = 1'b0; writeEnable = 1'b0;
        @(negedge clk);
        tests_run++;
        if (ramEn !== 1'b0 || busy !== 1'b0 || readData !== prev) begin
            tests_failed++;
            $display("[TB] FAIL priority_no_load: got en=%b busy=%b rd=%h expected 0/0/%h", ramEn, busy, readData, prev);
        end
        tests_run++;
        if (acc_log.size() != 1 || mem[0] !== 32'h12345678) begin
            tests_failed++;
            $display("[TB] FAIL priority_mem: got %0d accesses word0=%h expected 1 and 12345678", acc_log.size(), mem[0]);
        end
    endtask

    task automatic test_abort();
        logic [31:0] got;
        int st;
        bit to;
        preload(5, 32'hAABBCCDD);
        preload(6, 32'h11223344);
        @(posedge clk); #1;
        readEnable = 1'b1; addr = 32'h16; unitSize = MEM_W;
        @(negedge clk);
        @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b1; readEnable = 1'b0;
        @(negedge clk);
        tests_run++;
        if (busy !== 1'b0 || ramEn !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL abort_ld2_during: got busy=%b en=%b expected 0/0", busy, ramEn);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        acc_log.delete();
        @(negedge clk);
        tests_run++;
        if (busy !== 1'b0 || ramEn !== 1'b0 || readData !== 32'h0) begin
            tests_failed++;
            $display("[TB] FAIL abort_ld2_after: got busy=%b en=%b rd=%h expected 0/0/00000000", busy, ramEn, readData);
        end
        exp_q.push_back(32'hAABBCCDD);
        apply_load(32'h14, MEM_W, got, st, to);
        tests_run++;
        if (to || st != 1 || got !== exp_q.pop_front()) begin
            tests_failed++;
            $display("[TB] FAIL abort_then_load: got %h stalls %0d expected aabbccdd stalls 1", got, st);
        end
        preload(8, 32'h0);
        preload(9, 32'h0);
        @(posedge clk); #1;
        writeEnable = 1'b1; addr = 32'h22; unitSize = MEM_W; writeData = 32'hCAFEF00D;
        @(negedge clk);
        tests_run++;
        if (busy !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL abort_st_busy: got %b expected 1", busy);
        end
        @(posedge clk); #1;
        rst = 1'b1; writeEnable = 1'b0;
        @(negedge clk);
        tests_run++;
        if (ramEn !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL abort_st2_en: got %b expected 0", ramEn);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        tests_run++;
        if (mem[8] !== 32'hF00D0000 || mem[9] !== 32'h0) begin
            tests_failed++;
            $display("[TB] FAIL abort_st2_mem: got %h %h expected F00D0000 00000000", mem[8], mem[9]);
        end
    endtask

    initial begin
        test_reset();
        test_aligned_load();
        test_subword_loads();
        test_misaligned_load();
        test_stores();
        test_wrap();
        test_priority();
        test_abort();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

Data-memory controller between the core's MEM stage and a word-wide synchronous single-port SRAM. It accepts byte, halfword and word loads and stores, with RV32I funct3 encoding on `unitSize`. Misaligned accesses are split into two word accesses, and the core is stalled through `busy`. Loads are returned sign- or zero-extended.

## Interface
- `ADDR_W`, default 10: SRAM word-address width; depth = 2^ADDR_W words.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `readEnable`  in  1  load request; held stable by the core while `busy`=1.
- `writeEnable`  in  1  store request; held stable by the core while `busy`=1.
- `addr`  in  32  byte address.
- `unitSize`  in  3  funct3 code:
  - 000 B, 001 H, 010 W, 100 BU, 101 HU.
  - Any other code is treated as W.
- `writeData`  in  32  store data, LSB-aligned.
- `readData`  out  32  extended load result.
- `busy`  out  1  combinational stall to the core.
- `ramEn`  out  1  SRAM access enable.
- `ramWe`  out  4  per-byte write enables; bit i = byte lane i.
- `ramAddr`  out  ADDR_W  SRAM word address.
- `ramWData`  out  32  lane-positioned write data.
- `ramRData`  in  32  SRAM read data, valid 1 cycle after `ramEn` with `ramWe`=0.

## Operation
- Definitions:
  - Word index `w0 = addr[ADDR_W+1:2]`; `w1 = w0+1` mod 2^ADDR_W, so index 2^ADDR_W-1 wraps to 0.
  - Offset `off = addr[1:0]`; size in bytes `n` = 1, 2 or 4.
  - An access is misaligned iff `off + n > 4`: W with off≠0, or H with off=3. It uses lanes `off..3` of `w0` and lanes `0..off+n-5` of `w1`.
- Request priority: if `readEnable` and `writeEnable` are both 1, perform the store and ignore the load.
- State machine:
  - IDLE, no request: all `ram*` outputs are 0 and `busy`=0.
  - IDLE, aligned store: write `w0` with lane enables; `busy`=0; stay in IDLE.
  - IDLE, misaligned store: write the low part to `w0`; `busy`=1; go to ST2.
  - ST2: write the high part to `w1`; `busy`=0; go to IDLE.
  - IDLE, load: read `w0`; `busy`=1; go to LD1.
  - LD1, aligned: the result is formed from `ramRData`; `busy`=0; go to IDLE.
  - LD1, misaligned: register `ramRData` into `lo`; read `w1`; `busy`=1; go to LD2.
  - LD2: combine `{ramRData, lo}` shifted right by `8*off`; extend; `busy`=0; go to IDLE.
- Store lane positioning: `ramWData` is `writeData` shifted left by `8*off`, modulo 32 bits for the part written to `w0`. The part written to `w1` is `writeData` shifted right by `8*(4-off)`.
- Extension: B/H are sign-extended from bit 7/15; BU/HU are zero-extended; W passes through unchanged.
- `readData`:
  - In the completion cycle (`busy`=0 in LD1/LD2) it is the combinational extended value.
  - Otherwise it holds the last completed load value.
- The `busy`=0 cycle is the completion cycle. The core advances on that edge, so the next sample in IDLE is a new request.

## Timing
- Reset values: state IDLE; `busy`=0; `readData`=0; `lo`=0; `ramEn`=0; `ramWe`=0; `ramAddr`=0; `ramWData`=0.
- Latency:
  - Aligned store: 1 cycle.
  - Misaligned store: 2 cycles.
  - Aligned load: 2 cycles, with 1 stall cycle.
  - Misaligned load: 3 cycles, with 2 stall cycles.
- Reset in LD1, LD2 or ST2: return to IDLE on that edge. There is no further SRAM write for the aborted access, and `busy`=0 the following cycle.
- `busy` is a combinational function of state and request inputs only. It has no path from `ramRData`.

## Structure
- Package `riscv_mem_pkg` holds:
  - The funct3 size constants (`MEM_B`, `MEM_H`, `MEM_W`, `MEM_BU`, `MEM_HU`).
  - The state encoding (IDLE, LD1, LD2, ST2).
- Sub-module `load_formatter` is purely combinational. Inputs: 64-bit `{hi, lo}` window, `off`, and `unitSize`. Output: the extended 32-bit value.
- Store lane generation is inline in `dmem_ctrl`.

## Test plan
- Aligned LW: SRAM word 5 = 0x11223344, LW at addr 0x14. Expect `busy`=1 for 1 cycle, then `readData`=0x11223344 with `busy`=0.
- LB and LBU at addr 0x17, word 5 = 0x80FF0000. Expect LB → 0xFFFFFF80 and LBU → 0x00000080.
- Misaligned LW at addr 0x16, words 5/6 = 0xAABBCCDD / 0x11223344. Expect 2 stall cycles, reads of word indices 5 then 6, and `readData`=0x3344AABB.
- Misaligned SH at addr 0x0B, data 0xBEEF:
  - First cycle: `ramAddr`=2, `ramWe`=1000, `ramWData`=0xEF000000.
  - Second cycle: `ramAddr`=3, `ramWe`=0001, `ramWData`=0x000000BE.
- Wrap-around with `ADDR_W`=4: LW at addr 0x3E. Expect reads of word index 15, then 0.
- Abort and priority cases:
  - `rst` asserted in LD2: expect state IDLE, `busy`=0, and no `ramEn` the next cycle.
  - `readEnable`=`writeEnable`=1 at addr 0: expect a single write with `ramWe`=1111 and no LD1 entry.
